pad_io_ctrl: RTL and testbench

- Parametrised pad-control layer between SoC peripherals and a bank of NUM_PADS bidirectional pad cells. Successor to the fixed per-signal pad frame.
- Output/enable/pull paths are driven from per-pad config, as before.
- New input path per pad: synchroniser, optional debounce filter, configurable edge-event detection, sticky status and a single aggregated interrupt.

---
 rtl/pad_io_ctrl.sv | 155 +++++++++++++++
 tb/tb_pad_io_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pad_io_ctrl.sv
// pad_io_ctrl
//   Pad-control layer between SoC peripherals and NUM_PADS bidirectional pad
//   cells. The pad-side controls (output enable, output data, pull enable) are
//   purely combinational. The input path of each pad is: a synchroniser, an
//   optional debounce filter that produces the stable value in_o, edge-event
//   detection that drives evt_o, a sticky status flag, and one aggregated
//   interrupt.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   pad_cfg_i     per-pad config, CFG_W bits per pad:
//                 [0] pull enable, [1] filter enable,
//                 [3:2] event mode (00 off, 01 rise, 10 fall, 11 both)
//   deb_thresh_i  global debounce threshold T, in cycles
//   oe_i, out_i   peripheral output enable / data
//   in_o          synchronised, filtered pad input
//   pad_oen_o     pad cell OEN (= ~oe_i)
//   pad_i_o       pad cell I   (= out_i)
//   pad_pen_o     pad cell PEN (= ~pull enable)
//   pad_o_i       raw, asynchronous pad cell O
//   evt_o         one-cycle edge event pulses
//   status_o      sticky event flags
//   status_clr_i  write-1-to-clear pulses for status_o
//   irq_o         registered OR of status_o
module pad_io_ctrl #(
  parameter int NUM_PADS    = 32,
  parameter int CFG_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_PADS*CFG_W-1:0] pad_cfg_i,
  input  logic [DEB_W-1:0]          deb_thresh_i,
  input  logic [NUM_PADS-1:0]       oe_i,
  input  logic [NUM_PADS-1:0]       out_i,
  output logic [NUM_PADS-1:0]       in_o,
  output logic [NUM_PADS-1:0]       pad_oen_o,
  output logic [NUM_PADS-1:0]       pad_i_o,
  output logic [NUM_PADS-1:0]       pad_pen_o,
  input  logic [NUM_PADS-1:0]       pad_o_i,
  output logic [NUM_PADS-1:0]       evt_o,
  output logic [NUM_PADS-1:0]       status_o,
  input  logic [NUM_PADS-1:0]       status_clr_i,
  output logic                      irq_o
);

  // Events are held off for SYNC_STAGES+1 cycles after reset so that pads
  // already sitting high (e.g. pulled up) do not report a spurious rise
  // while the synchroniser and stable register fill.
  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(ARM_N + 1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_PADS];
  logic [DEB_W-1:0]       cnt_q  [NUM_PADS];
  logic [DEB_W-1:0]       cnt_d  [NUM_PADS];
  logic [NUM_PADS-1:0]    s_w;
  logic [NUM_PADS-1:0]    stable_q;
  logic [NUM_PADS-1:0]    stable_d;
  logic [NUM_PADS-1:0]    evt_q;
  logic [NUM_PADS-1:0]    evt_d;
  logic [NUM_PADS-1:0]    status_q;
  logic                   irq_q;
  logic [ARM_W-1:0]       arm_q;
  logic                   armed;
  logic                   thresh_le1;

  // Pad-side controls: combinational, independent of reset.
  always_comb begin
    pad_oen_o = ~oe_i;
    pad_i_o   = out_i;
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_pen_o[i] = ~pad_cfg_i[i*CFG_W];
    end
  end

  assign armed      = (arm_q == ARM_W'(ARM_N));
  assign thresh_le1 = (deb_thresh_i <= DEB_W'(1));

  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      s_w[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Debounce and event decode. The count is compared in DEB_W+1 bits so that
  // lowering the threshold below the current count simply makes the next
  // mismatch cycle commit; the counter never wraps.
  always_comb begin
    logic       filt_en;
    logic [1:0] mode;
    logic       upd;
    filt_en  = 1'b0;
    mode     = 2'b00;
    upd      = 1'b0;
    stable_d = stable_q;
    evt_d    = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      cnt_d[i] = '0;
      filt_en  = pad_cfg_i[i*CFG_W + 1];
      mode     = pad_cfg_i[i*CFG_W + 2 +: 2];
      if (!filt_en || thresh_le1) begin
        stable_d[i] = s_w[i];
      end else if (s_w[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + (DEB_W+1)'(1)) >= {1'b0, deb_thresh_i}) begin
        stable_d[i] = s_w[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
      upd = stable_d[i] ^ stable_q[i];
      case (mode)
        2'b01:   evt_d[i] = armed & upd &  stable_d[i];
        2'b10:   evt_d[i] = armed & upd & ~stable_d[i];
        2'b11:   evt_d[i] = armed & upd;
        default: evt_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q <= '0;
      evt_q    <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      arm_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad_o_i[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      stable_q <= stable_d;
      evt_q    <= evt_d;
      // A new event wins over a simultaneous clear.
      status_q <= evt_q | (status_q & ~status_clr_i);
      irq_q    <= |status_q;
      if (!armed) begin
        arm_q <= arm_q + ARM_W'(1);
      end
    end
  end

  assign in_o     = stable_q;
  assign evt_o    = evt_q;
  assign status_o = status_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
module tb_pad_io_ctrl;

  localparam int NUM_PADS = 32;
  localparam int CFG_W    = 6;
  localparam int DEB_W    = 8;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic [NUM_PADS*CFG_W-1:0] pad_cfg_i;
  logic [DEB_W-1:0]          deb_thresh_i;
  logic [NUM_PADS-1:0]       oe_i;
  logic [NUM_PADS-1:0]       out_i;
  logic [NUM_PADS-1:0]       in_o;
  logic [NUM_PADS-1:0]       pad_oen_o;
  logic [NUM_PADS-1:0]       pad_i_o;
  logic [NUM_PADS-1:0]       pad_pen_o;
  logic [NUM_PADS-1:0]       pad_o_i;
  logic [NUM_PADS-1:0]       evt_o;
  logic [NUM_PADS-1:0]       status_o;
  logic [NUM_PADS-1:0]       status_clr_i;
  logic                      irq_o;

  int checks = 0;
  int errors = 0;

  // Expected {in_o[p], evt_o[p]} per cycle for the sequence being run.
  logic [1:0] exp_q[$];

  pad_io_ctrl #(
    .NUM_PADS(NUM_PADS), .CFG_W(CFG_W), .SYNC_STAGES(2), .DEB_W(DEB_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pad_cfg_i(pad_cfg_i),
    .deb_thresh_i(deb_thresh_i), .oe_i(oe_i), .out_i(out_i), .in_o(in_o),
    .pad_oen_o(pad_oen_o), .pad_i_o(pad_i_o), .pad_pen_o(pad_pen_o),
    .pad_o_i(pad_o_i), .evt_o(evt_o), .status_o(status_o),
    .status_clr_i(status_clr_i), .irq_o(irq_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int pad, input logic [CFG_W-1:0] v);
    pad_cfg_i[pad*CFG_W +: CFG_W] = v;
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_pad_seq(input int pad, input int ncyc, input string tag);
    logic [1:0] e;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (exp_q.size() == 0) begin
        chk({tag, "_q_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_in_k%0d", tag, k), {31'd0, in_o[pad]}, {31'd0, e[1]});
        chk($sformatf("%s_evt_k%0d", tag, k), {31'd0, evt_o[pad]}, {31'd0, e[0]});
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    pad_cfg_i    = '0;
    deb_thresh_i = '0;
    oe_i         = '0;
    out_i        = '0;
    pad_o_i      = '0;
    status_clr_i = '0;
    tick();
    tick();

    // reset state
    chk("rst_in", in_o, 32'h0);
    chk("rst_evt", evt_o, 32'h0);
    chk("rst_status", status_o, 32'h0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);

    // pad-side outputs, combinational and unaffected by reset
    set_cfg(2, 6'b000001);
    oe_i[2]  = 1'b1;
    out_i[2] = 1'b1;
    #1;
    chk("pen", pad_pen_o, 32'hFFFF_FFFB);
    chk("oen", pad_oen_o, 32'hFFFF_FFFB);
    chk("pad_i", pad_i_o, 32'h0000_0004);
    tick();
    chk("pen_rst", pad_pen_o, 32'hFFFF_FFFB);
    chk("oen_rst", pad_oen_o, 32'hFFFF_FFFB);
    chk("pad_i_rst", pad_i_o, 32'h0000_0004);

    // arm window: pad 3 high from the first cycle out of reset, mode rise
    set_cfg(3, 6'b000100);
    pad_o_i[3] = 1'b1;
    rst_i      = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("arm_in3_k%0d", k), {31'd0, in_o[3]}, {31'd0, (k >= 2)});
      chk($sformatf("arm_evt_k%0d", k), evt_o, 32'h0);
    end
    chk("arm_status", status_o, 32'h0);

    // armed, filter off, mode both on pad 5: rise at k=0, fall at k=10
    set_cfg(5, 6'b001100);
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back({(k >= 2 && k < 12), (k == 2 || k == 12)});
    end
    fork
      run_pad_seq(5, 20, "both5");
      begin
        pad_o_i[5] = 1'b1;
        repeat (10) @(posedge clk_i);
        #1 pad_o_i[5] = 1'b0;
      end
    join
    chk("both5_status", status_o, 32'h0000_0020);
    chk("both5_irq", {31'd0, irq_o}, 32'd1);

    // filter on, T=4, pad 0, mode rise: 3-cycle glitch is rejected
    deb_thresh_i = 8'd4;
    set_cfg(0, 6'b000110);
    for (int k = 0; k < 12; k++) exp_q.push_back(2'b00);
    fork
      run_pad_seq(0, 12, "glitch0");
      begin
        pad_o_i[0] = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 pad_o_i[0] = 1'b0;
      end
    join
    // 4-cycle pulse: in_o high after edge 5 (6 edges incl. the sampling one),
    // falls again after four more low cycles at s; only the rise reports
    for (int k = 0; k < 14; k++) begin
      exp_q.push_back({(k >= 5 && k < 9), (k == 5)});
    end
    fork
      run_pad_seq(0, 14, "pulse0");
      begin
        pad_o_i[0] = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 pad_o_i[0] = 1'b0;
      end
    join

    // filter on, T=200, pad 1: counter reaches 150 after edge 151, then
    // T drops to 100 and the next edge commits
    deb_thresh_i = 8'd200;
    set_cfg(1, 6'b000010);
    pad_o_i[1] = 1'b1;
    repeat (152) tick();
    chk("thr_before", {31'd0, in_o[1]}, 32'd0);
    deb_thresh_i = 8'd100;
    tick();
    chk("thr_after", {31'd0, in_o[1]}, 32'd1);

    // clear everything, irq follows one cycle later
    status_clr_i = '1;
    tick();
    status_clr_i = '0;
    chk("clr_all_status", status_o, 32'h0);
    tick();
    chk("clr_all_irq", {31'd0, irq_o}, 32'd0);

    // pad 7, mode both: status set, then clear collides with a new event
    set_cfg(7, 6'b001100);
    pad_o_i[7] = 1'b1;
    repeat (4) tick();
    chk("st7_set", status_o, 32'h0000_0080);
    pad_o_i[7] = 1'b0;
    repeat (3) tick();
    chk("st7_evt_fall", evt_o, 32'h0000_0080);
    status_clr_i[7] = 1'b1;
    tick();
    chk("st7_set_wins", status_o, 32'h0000_0080);
    tick();
    status_clr_i[7] = 1'b0;
    chk("st7_cleared", status_o, 32'h0);
    chk("st7_irq_still", {31'd0, irq_o}, 32'd1);
    tick();
    chk("st7_irq_drop", {31'd0, irq_o}, 32'd0);

    // reset mid-operation discards state
    pad_o_i[5] = 1'b1;
    repeat (4) tick();
    chk("mid_status_pre", status_o, 32'h0000_0020);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_in", in_o, 32'h0);
    chk("mid_rst_status", status_o, 32'h0);
    chk("mid_rst_evt", evt_o, 32'h0);
    rst_i = 1'b0;

    if (exp_q.size() != 0) chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
